// File: rtl/i2s_transmitter.sv
// i2s_transmitter: master-mode I2S transmitter.
//   Divides clk into BCLK/LRCLK, serialises {L, pad, R, pad} frames MSB first with
//   the one-bit I2S delay, and takes sample pairs over a valid/ready handshake into
//   a one-frame holding register. Shift/load strobes let a receiver run in loopback.
// Ports:
//   clk, reset (async, active-low)
//   enable                     run request
//   sample_l/sample_r/valid    PCM pair input; sample_ready = holding register empty
//   underrun                   1-clk pulse: frame started with holding register empty
//   busy                       high while running or finishing the last frame
//   i2s_bclk/i2s_lrclk/i2s_data  serial bus (lrclk 0 = left slot)
//   i2s_data_shift_strobe      pulse in the clk where bclk rises
//   i2s_data_load_strobe       pulse one clk after the shift strobe of a slot's final bit
module i2s_transmitter #(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned SLOT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [SAMPLE_WIDTH-1:0] sample_l,
  input  logic [SAMPLE_WIDTH-1:0] sample_r,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  output logic                    underrun,
  output logic                    busy,
  output logic                    i2s_bclk,
  output logic                    i2s_lrclk,
  output logic                    i2s_data,
  output logic                    i2s_data_shift_strobe,
  output logic                    i2s_data_load_strobe
);

  localparam int unsigned FRAME = 2 * SLOT_WIDTH;
  localparam int unsigned PAD   = SLOT_WIDTH - SAMPLE_WIDTH;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = $clog2(FRAME);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic               first_q, first_d;
  logic               bclk_q, bclk_d;
  logic               lrclk_q, lrclk_d;
  logic               data_q, data_d;
  logic               shift_q, shift_d;
  logic               load_q, load_d;
  logic               underrun_q, underrun_d;
  logic               busy_q, busy_d;
  logic               empty_q, empty_d;
  logic [FRAME-1:0]   hold_q, hold_d;
  logic [FRAME-1:0]   active_q, active_d;
  logic [BIT_W-1:0]   bit_nxt;
  logic [BIT_W-1:0]   idx;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      first_q    <= 1'b0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      data_q     <= 1'b0;
      shift_q    <= 1'b0;
      load_q     <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      empty_q    <= 1'b1;
      hold_q     <= '0;
      active_q   <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      first_q    <= first_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      load_q     <= load_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      empty_q    <= empty_d;
      hold_q     <= hold_d;
      active_q   <= active_d;
    end
  end

  // Next-state: divider, bit counter, frame start, handshake
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    first_d    = first_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    data_d     = data_q;
    shift_d    = 1'b0;
    load_d     = 1'b0;
    underrun_d = 1'b0;
    empty_d    = empty_q;
    hold_d     = hold_q;
    active_d   = active_q;
    bit_nxt    = '0;
    idx        = '0;

    // Accept a pair whenever the holding register is empty, in any state
    if (sample_valid && empty_q) begin
      hold_d  = (FRAME'(sample_l) << (SLOT_WIDTH + PAD)) | (FRAME'(sample_r) << PAD);
      empty_d = 1'b0;
    end

    // Bit counter is stable for CLK_DIV clks after the rising edge, so it still names the shifted bit
    if (state_q != S_IDLE) begin
      load_d = shift_q && ((bit_q == BIT_W'(SLOT_WIDTH)) || (bit_q == '0));
    end

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          // bclk starts high so the first edge after CLK_DIV clks is the frame-start fall
          state_d = S_RUN;
          bclk_d  = 1'b1;
          div_d   = '0;
          first_d = 1'b1;
        end
      end
      default: begin
        if ((state_q == S_RUN) && !enable) begin
          state_d = S_STOP;
        end
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!bclk_q) begin
            bclk_d  = 1'b1;
            shift_d = 1'b1;
          end else begin
            bclk_d = 1'b0;
            if ((state_q == S_STOP) && !first_q && (bit_q == BIT_W'(FRAME - 1))) begin
              state_d = S_IDLE;
              lrclk_d = 1'b0;
              data_d  = 1'b0;
              bit_d   = '0;
            end else begin
              first_d = 1'b0;
              bit_nxt = (first_q || (bit_q == BIT_W'(FRAME - 1))) ? '0 : bit_q + BIT_W'(1);
              bit_d   = bit_nxt;
              lrclk_d = (bit_nxt >= BIT_W'(SLOT_WIDTH));
              if (bit_nxt == '0) begin
                // Bit 0 carries the outgoing frame's LSB; nothing precedes the first frame
                data_d = first_q ? 1'b0 : active_q[0];
                if (!empty_q) begin
                  active_d = hold_q;
                  empty_d  = 1'b1;
                end else begin
                  underrun_d = 1'b1;
                end
              end else begin
                // One-bit I2S delay: bit period b carries word bit b-1 counted from the MSB
                idx    = BIT_W'(FRAME - 32'(bit_nxt));
                data_d = active_q[idx];
              end
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign sample_ready          = empty_q;
  assign underrun              = underrun_q;
  assign busy                  = busy_q;
  assign i2s_bclk              = bclk_q;
  assign i2s_lrclk             = lrclk_q;
  assign i2s_data              = data_q;
  assign i2s_data_shift_strobe = shift_q;
  assign i2s_data_load_strobe  = load_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: two instances (16-bit slots and 24-bit slots).
module tb_i2s_transmitter;

  typedef struct packed {
    logic d;
    logic lr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: CLK_DIV=2, 16-bit samples in 16-bit slots
  logic        reset_a, en_a, val_a;
  logic [15:0] sl_a, sr_a;
  logic        ready_a, und_a, busy_a, bclk_a, lr_a, data_a, shift_a, load_a;

  // Instance B: CLK_DIV=2, 16-bit samples in 24-bit slots
  logic        reset_b, en_b, val_b;
  logic [15:0] sl_b, sr_b;
  logic        ready_b, und_b, busy_b, bclk_b, lr_b, data_b, shift_b, load_b;

  i2s_transmitter #(.CLK_DIV(2), .SAMPLE_WIDTH(16), .SLOT_WIDTH(16)) u_dut_a (
    .clk(clk), .reset(reset_a), .enable(en_a),
    .sample_l(sl_a), .sample_r(sr_a), .sample_valid(val_a), .sample_ready(ready_a),
    .underrun(und_a), .busy(busy_a), .i2s_bclk(bclk_a), .i2s_lrclk(lr_a), .i2s_data(data_a),
    .i2s_data_shift_strobe(shift_a), .i2s_data_load_strobe(load_a)
  );

  i2s_transmitter #(.CLK_DIV(2), .SAMPLE_WIDTH(16), .SLOT_WIDTH(24)) u_dut_b (
    .clk(clk), .reset(reset_b), .enable(en_b),
    .sample_l(sl_b), .sample_r(sr_b), .sample_valid(val_b), .sample_ready(ready_b),
    .underrun(und_b), .busy(busy_b), .i2s_bclk(bclk_b), .i2s_lrclk(lr_b), .i2s_data(data_b),
    .i2s_data_shift_strobe(shift_b), .i2s_data_load_strobe(load_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  exp_t        qa[$];
  exp_t        qb[$];
  logic [31:0] rxq[$];
  int          nshift_a = 0, nload_a = 0, nund_a = 0, nrl_a = 0;
  int          nshift_b = 0;
  logic        done_b = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_frame_a(input logic [31:0] w);
    exp_t e;
    for (int k = 0; k < 32; k++) begin
      e.d  = w[31-k];
      e.lr = (((k + 1) % 32) >= 16);
      qa.push_back(e);
    end
  endtask

  task automatic push_frame_b(input logic [47:0] w);
    exp_t e;
    for (int k = 0; k < 48; k++) begin
      e.d  = w[47-k];
      e.lr = (((k + 1) % 48) >= 24);
      qb.push_back(e);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(ready_a), 64'(1));
    chk({tag, "_underrun"}, 64'(und_a), 64'(0));
    chk({tag, "_busy"}, 64'(busy_a), 64'(0));
    chk({tag, "_bclk"}, 64'(bclk_a), 64'(0));
    chk({tag, "_lrclk"}, 64'(lr_a), 64'(0));
    chk({tag, "_data"}, 64'(data_a), 64'(0));
    chk({tag, "_shift"}, 64'(shift_a), 64'(0));
    chk({tag, "_load"}, 64'(load_a), 64'(0));
  endtask

  // Monitor A: bit scoreboard plus a loopback receiver driven by the strobes
  initial begin : mon_a
    exp_t        e;
    logic [15:0] rx_sr = '0;
    logic [15:0] rx_l = '0;
    logic [15:0] rx_r = '0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (shift_a) begin
        nshift_a++;
        rx_sr = {rx_sr[14:0], data_a};
        if (qa.size() == 0) begin
          chk("a_unexpected_bit", 64'(1), 64'(0));
        end else begin
          e = qa.pop_front();
          chk("a_data", 64'(data_a), 64'(e.d));
          chk("a_lrclk", 64'(lr_a), 64'(e.lr));
        end
      end
      if (load_a) begin
        nload_a++;
        if (lr_a) begin
          rx_l = rx_sr;
        end else begin
          rx_r = rx_sr;
          nrl_a++;
          // The first right-complete load closes the empty slot before frame 0
          if (nrl_a > 1 && rxq.size() != 0) begin
            w = rxq.pop_front();
            chk("a_rx_left", 64'(rx_l), 64'(w[31:16]));
            chk("a_rx_right", 64'(rx_r), 64'(w[15:0]));
          end
        end
      end
      if (und_a) nund_a++;
    end
  end

  // Monitor B: bit scoreboard for the padded-slot instance
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (shift_b) begin
        nshift_b++;
        if (qb.size() == 0) begin
          chk("b_unexpected_bit", 64'(1), 64'(0));
        end else begin
          e = qb.pop_front();
          chk("b_data", 64'(data_b), 64'(e.d));
          chk("b_lrclk", 64'(lr_b), 64'(e.lr));
        end
      end
    end
  end

  // lrclk half-period measurement on A: 16 bits of 4 clk each
  initial begin : lr_meas
    int n;
    n = 0;
    while (!lr_a && n < 5000) begin @(negedge clk); n++; end
    chk("a_lrclk_rise_timeout", 64'(n < 5000), 64'(1));
    n = 0;
    while (lr_a && n < 1000) begin n++; @(negedge clk); end
    chk("a_lrclk_high_clks", 64'(n), 64'(64));
    n = 0;
    while (!lr_a && n < 1000) begin n++; @(negedge clk); end
    chk("a_lrclk_low_clks", 64'(n), 64'(64));
  end

  // Stimulus B: one frame with 8-bit zero pads, stopped early
  initial begin : stim_b
    int   n;
    exp_t e;
    reset_b = 1'b1; en_b = 1'b0; val_b = 1'b0; sl_b = '0; sr_b = '0;
    #1 reset_b = 1'b0;
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    e.d = 1'b0; e.lr = 1'b0;
    qb.push_back(e);
    push_frame_b({16'hC3A5, 8'h00, 16'h5A3C, 8'h00});
    sl_b = 16'hC3A5; sr_b = 16'h5A3C; val_b = 1'b1;
    @(negedge clk);
    val_b = 1'b0; en_b = 1'b1;
    n = 0;
    while (nshift_b < 10 && n < 5000) begin @(negedge clk); n++; end
    en_b = 1'b0;
    n = 0;
    while (!(busy_b == 1'b0 && nshift_b > 0) && n < 5000) begin @(negedge clk); n++; end
    chk("b_stop_timeout", 64'(n < 5000), 64'(1));
    chk("b_shift_count", 64'(nshift_b), 64'(48));
    chk("b_queue_left", 64'(qb.size()), 64'(1));
    chk("b_underrun", 64'(und_b), 64'(0));
    done_b = 1'b1;
  end

  // Stimulus A: handshake, underrun repeats, stop, async reset mid-frame
  initial begin : stim_a
    int   n;
    int   base;
    exp_t e;
    reset_a = 1'b1; en_a = 1'b0; val_a = 1'b0; sl_a = '0; sr_a = '0;
    #1 reset_a = 1'b0;
    #1 chk_reset_outputs("a_reset");
    repeat (3) @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);

    e.d = 1'b0; e.lr = 1'b0;
    qa.push_back(e);
    push_frame_a({16'h1234, 16'h5678});
    repeat (4) push_frame_a({16'hA5F0, 16'h0FF1});
    rxq.push_back({16'h1234, 16'h5678});
    repeat (3) rxq.push_back({16'hA5F0, 16'h0FF1});

    sl_a = 16'h1234; sr_a = 16'h5678; val_a = 1'b1;
    @(negedge clk);
    chk("a_ready_after_push", 64'(ready_a), 64'(0));
    sl_a = 16'hA5F0; sr_a = 16'h0FF1; en_a = 1'b1;
    @(negedge clk);
    chk("a_busy_run", 64'(busy_a), 64'(1));
    chk("a_bclk_start_high", 64'(bclk_a), 64'(1));
    chk("a_ready_held_full", 64'(ready_a), 64'(0));
    n = 1;
    while (!ready_a && n < 200) begin @(negedge clk); n++; end
    chk("a_first_fall_clks", 64'(n), 64'(3));
    chk("a_bclk_frame_start", 64'(bclk_a), 64'(0));
    @(negedge clk);
    val_a = 1'b0;
    chk("a_ready_after_second", 64'(ready_a), 64'(0));

    n = 0;
    while (nshift_a < 134 && n < 5000) begin @(negedge clk); n++; end
    chk("a_bit5_timeout", 64'(n < 5000), 64'(1));
    en_a = 1'b0;
    n = 0;
    while (busy_a && n < 5000) begin @(negedge clk); n++; end
    chk("a_stop_timeout", 64'(n < 5000), 64'(1));
    chk("a_idle_bclk", 64'(bclk_a), 64'(0));
    chk("a_idle_lrclk", 64'(lr_a), 64'(0));
    chk("a_idle_data", 64'(data_a), 64'(0));
    chk("a_shift_count", 64'(nshift_a), 64'(160));
    chk("a_queue_left", 64'(qa.size()), 64'(1));
    chk("a_underrun_count", 64'(nund_a), 64'(3));
    chk("a_load_count", 64'(nload_a), 64'(10));
    chk("a_rx_pending", 64'(rxq.size()), 64'(0));
    chk("a_ready_idle", 64'(ready_a), 64'(1));

    // Restart: bit 0 must be 0 again, then reset lands at bit 10 with holding full
    qa.delete();
    e.d = 1'b0; e.lr = 1'b0;
    qa.push_back(e);
    push_frame_a({16'h8001, 16'h7FFE});
    base = nshift_a;
    sl_a = 16'h8001; sr_a = 16'h7FFE; val_a = 1'b1;
    @(negedge clk);
    sl_a = 16'h4444; sr_a = 16'h3333; en_a = 1'b1;
    n = 0;
    while (!ready_a && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    val_a = 1'b0;
    chk("a_ready_full_before_reset", 64'(ready_a), 64'(0));
    n = 0;
    while (nshift_a < base + 11 && n < 5000) begin @(negedge clk); n++; end
    chk("a_bit10_timeout", 64'(n < 5000), 64'(1));
    #2 reset_a = 1'b0;
    #1 chk_reset_outputs("a_midreset");
    en_a = 1'b0;
    @(negedge clk);
    reset_a = 1'b1;
    @(negedge clk);
    chk("a_ready_after_reset", 64'(ready_a), 64'(1));
    chk("a_busy_after_reset", 64'(busy_a), 64'(0));

    n = 0;
    while (!done_b && n < 5000) begin @(negedge clk); n++; end
    chk("b_done_timeout", 64'(done_b), 64'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
